rob_superscalar: RTL and testbench

- N-way in-order-retire reorder buffer for the R10K-style out-of-order core.
- Sits between dispatch and retire. Accepts up to N instructions per cycle from dispatch and records completion events from the CDB.
- Retires up to N completed instructions per cycle in program order, producing Told for the free list and T for the architectural map table.
- Performs retire-time mispredict recovery by flushing every younger entry.

---
 rtl/sys_defs.sv | 39 +++
 rtl/rob_retire_select.sv | 39 +++
 rtl/rob_superscalar.sv | 97 +++++++++
 tb/tb_rob_superscalar.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared types for the out-of-order core: register indices and the ROB
// dispatch/retire packets.
`ifndef N
`define N 3
`endif

package sys_defs;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int ROB_DEPTH = 32;

  typedef logic [$clog2(ARCH_REGS)-1:0] ARCH_REG_IDX;
  typedef logic [$clog2(PHYS_REGS)-1:0] PHYS_REG_IDX;
  typedef logic [$clog2(ROB_DEPTH)-1:0] ROB_IDX;

  typedef struct packed {
    ARCH_REG_IDX dest_arch;
    PHYS_REG_IDX T;
    PHYS_REG_IDX Told;
    logic        has_dest;
    logic        is_branch;
  } ROB_ENTRY_PACKET;

  typedef struct packed {
    ARCH_REG_IDX dest_arch;
    PHYS_REG_IDX T;
    PHYS_REG_IDX Told;
    logic        has_dest;
  } ROB_EXIT_PACKET;

  function automatic ROB_EXIT_PACKET to_exit(ROB_ENTRY_PACKET p);
    ROB_EXIT_PACKET e;
    e.dest_arch = p.dest_arch;
    e.T         = p.T;
    e.Told      = p.Told;
    e.has_dest  = p.has_dest;
    return e;
  endfunction
endpackage

// File: rtl/rob_retire_select.sv
// Picks the in-order prefix of completed entries at the ROB head; a retiring
// mispredicted branch ends the group and raises flush.
module rob_retire_select #(
  parameter int DEPTH    = 32,
  parameter int N        = `N,
  parameter int IDX_BITS = $clog2(DEPTH),
  parameter int CNT_BITS = $clog2(N+1)
) (
  input  logic [IDX_BITS-1:0] head,
  input  logic [IDX_BITS:0]   entries,
  input  logic [DEPTH-1:0]    complete,
  input  logic [DEPTH-1:0]    mispredict,
  output logic [N-1:0]        retire_valid,
  output logic [CNT_BITS-1:0] retire_cnt,
  output logic                flush
);
  always_comb begin
    logic                alive;
    logic [IDX_BITS-1:0] idx;
    retire_valid = '0;
    retire_cnt   = '0;
    flush        = 1'b0;
    alive        = 1'b1;
    idx          = '0;
    for (int i = 0; i < N; i++) begin
      idx = head + IDX_BITS'(i);
      if (alive && ((IDX_BITS+1)'(i) < entries) && complete[idx]) begin
        retire_valid[i] = 1'b1;
        retire_cnt      = retire_cnt + CNT_BITS'(1);
        if (mispredict[idx]) begin
          flush = 1'b1;
          alive = 1'b0;
        end
      end else begin
        alive = 1'b0;
      end
    end
  end
endmodule

// File: rtl/rob_superscalar.sv
// N-wide reorder buffer: dispatch into the tail, mark completions from the CDB,
// retire in order from the head, and flush everything younger on a mispredict.
module rob_superscalar
  import sys_defs::*;
#(
  parameter int DEPTH    = 32,
  parameter int N        = `N,
  parameter int IDX_BITS = $clog2(DEPTH),
  parameter int CNT_BITS = $clog2(N+1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CNT_BITS-1:0]          dispatch_cnt,
  input  ROB_ENTRY_PACKET [N-1:0]      dispatch_entries,
  output logic [N-1:0][IDX_BITS-1:0]   dispatch_idx,
  output logic [CNT_BITS-1:0]          spots,
  output logic                         full,
  input  logic [N-1:0]                 complete_valid,
  input  logic [N-1:0][IDX_BITS-1:0]   complete_idx,
  input  logic [N-1:0]                 complete_mispredict,
  output logic [N-1:0]                 retire_valid,
  output ROB_EXIT_PACKET [N-1:0]       retire_entries,
  output logic                         flush
);
  ROB_ENTRY_PACKET     rob_pkt [DEPTH];
  logic [DEPTH-1:0]    complete, mispred, cpl_set, mp_val;
  logic [IDX_BITS-1:0] head, tail;
  logic [IDX_BITS:0]   entries, free_slots;
  logic [CNT_BITS-1:0] accepted, retire_cnt;

  // Spots come from the registered count only; same-cycle retires free nothing.
  assign free_slots = (IDX_BITS+1)'(DEPTH) - entries;
  assign spots      = (free_slots < (IDX_BITS+1)'(N)) ? CNT_BITS'(free_slots) : CNT_BITS'(N);
  assign full       = (entries == (IDX_BITS+1)'(DEPTH));
  assign accepted   = (dispatch_cnt < spots) ? dispatch_cnt : spots;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign dispatch_idx[i]   = tail + IDX_BITS'(i);
    assign retire_entries[i] = to_exit(rob_pkt[head + IDX_BITS'(i)]);
  end

  rob_retire_select #(
    .DEPTH(DEPTH), .N(N), .IDX_BITS(IDX_BITS), .CNT_BITS(CNT_BITS)
  ) u_sel (
    .head        (head),
    .entries     (entries),
    .complete    (complete),
    .mispredict  (mispred),
    .retire_valid(retire_valid),
    .retire_cnt  (retire_cnt),
    .flush       (flush)
  );

  // Collapse the completion lanes per entry so duplicate indices OR their mispredict bits.
  always_comb begin
    cpl_set = '0;
    mp_val  = '0;
    for (int i = 0; i < N; i++) begin
      if (complete_valid[i]) begin
        cpl_set[complete_idx[i]] = 1'b1;
        mp_val[complete_idx[i]]  = mp_val[complete_idx[i]] | complete_mispredict[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      entries  <= '0;
      complete <= '0;
      mispred  <= '0;
    end else if (flush) begin
      head     <= head + IDX_BITS'(retire_cnt);
      tail     <= head + IDX_BITS'(retire_cnt);
      entries  <= '0;
      complete <= '0;
    end else begin
      for (int d = 0; d < DEPTH; d++) begin
        if (cpl_set[d]) begin
          complete[d] <= 1'b1;
          mispred[d]  <= mp_val[d];
        end
      end
      for (int i = 0; i < N; i++) begin
        if (CNT_BITS'(i) < accepted) begin
          rob_pkt[tail + IDX_BITS'(i)]  <= dispatch_entries[i];
          complete[tail + IDX_BITS'(i)] <= 1'b0;
          mispred[tail + IDX_BITS'(i)]  <= 1'b0;
        end
      end
      head    <= head + IDX_BITS'(retire_cnt);
      tail    <= tail + IDX_BITS'(accepted);
      entries <= entries + (IDX_BITS+1)'(accepted) - (IDX_BITS+1)'(retire_cnt);
    end
  end
endmodule

// File: tb/tb_rob_superscalar.sv
// Bench for rob_superscalar (DEPTH=8, N=3): queue-based reference model,
// per-cycle output comparison, directed scenarios and random traffic.
module tb_rob_superscalar;
  import sys_defs::*;
  localparam int DEPTH = 8;
  localparam int N     = 3;
  localparam int IB    = 3;
  localparam int CB    = 2;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic [CB-1:0]           dispatch_cnt;
  ROB_ENTRY_PACKET [N-1:0] dispatch_entries;
  logic [N-1:0][IB-1:0]    dispatch_idx;
  logic [CB-1:0]           spots;
  logic                    full;
  logic [N-1:0]            complete_valid, complete_mispredict, retire_valid;
  logic [N-1:0][IB-1:0]    complete_idx;
  ROB_EXIT_PACKET [N-1:0]  retire_entries;
  logic                    flush;

  rob_superscalar #(.DEPTH(DEPTH), .N(N)) dut (
    .clock(clock), .reset(reset),
    .dispatch_cnt(dispatch_cnt), .dispatch_entries(dispatch_entries),
    .dispatch_idx(dispatch_idx), .spots(spots), .full(full),
    .complete_valid(complete_valid), .complete_idx(complete_idx),
    .complete_mispredict(complete_mispredict),
    .retire_valid(retire_valid), .retire_entries(retire_entries), .flush(flush)
  );

  always #5 clock = ~clock;

  typedef struct { ROB_ENTRY_PACKET p; bit done; bit mp; } m_ent_t;
  m_ent_t q[$];
  int     mhead   = 0;
  bit     started = 1'b0;
  int     checks  = 0;
  int     failures = 0;
  int     seq     = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_spots();
    return ((DEPTH - q.size()) < N) ? (DEPTH - q.size()) : N;
  endfunction

  // Oldest-first: take completed entries until one is not done or a mispredict retires.
  function automatic void m_retire(output int r, output bit fl);
    r  = 0;
    fl = 1'b0;
    for (int k = 0; k < N && k < q.size(); k++) begin
      if (!q[k].done) break;
      r++;
      if (q[k].mp) begin
        fl = 1'b1;
        break;
      end
    end
  endfunction

  task automatic model_step();
    int r, acc, k;
    bit fl;
    bit [DEPTH-1:0] hit;
    m_retire(r, fl);
    acc = (int'(dispatch_cnt) < m_spots()) ? int'(dispatch_cnt) : m_spots();
    hit = '0;
    if (reset) begin
      q.delete();
      mhead = 0;
    end else if (fl) begin
      mhead = (mhead + r) % DEPTH;
      q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (complete_valid[i]) begin
          k = (int'(complete_idx[i]) - mhead + DEPTH) % DEPTH;
          if (k < q.size()) begin
            q[k].done = 1'b1;
            q[k].mp   = hit[k] ? (q[k].mp | complete_mispredict[i]) : complete_mispredict[i];
            hit[k]    = 1'b1;
          end
        end
      end
      for (int j = 0; j < r; j++) void'(q.pop_front());
      mhead = (mhead + r) % DEPTH;
      for (int i = 0; i < acc; i++) q.push_back('{p: dispatch_entries[i], done: 1'b0, mp: 1'b0});
    end
  endtask

  always @(negedge clock) begin : cmp
    int r, t;
    bit fl;
    if (started) begin
      m_retire(r, fl);
      t = (mhead + q.size()) % DEPTH;
      chk("spots", int'(spots), m_spots());
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("flush", int'(flush), int'(fl));
      chk("retire_valid", int'(retire_valid), (1 << r) - 1);
      for (int i = 0; i < N; i++) chk("dispatch_idx", int'(dispatch_idx[i]), (t + i) % DEPTH);
      for (int i = 0; i < r; i++) begin
        chk("ret_T", int'(retire_entries[i].T), int'(q[i].p.T));
        chk("ret_Told", int'(retire_entries[i].Told), int'(q[i].p.Told));
        chk("ret_dest", int'(retire_entries[i].dest_arch), int'(q[i].p.dest_arch));
        chk("ret_has_dest", int'(retire_entries[i].has_dest), int'(q[i].p.has_dest));
      end
    end
  end

  task automatic idle();
    logic [31:0] rv;
    dispatch_cnt        = '0;
    complete_valid      = '0;
    complete_mispredict = '0;
    complete_idx        = '0;
    for (int i = 0; i < N; i++) begin
      rv = $urandom;
      dispatch_entries[i] = rv[$bits(ROB_ENTRY_PACKET)-1:0];
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    idle();
  endtask

  task automatic disp(int cnt);
    dispatch_cnt = CB'(cnt);
    for (int i = 0; i < N; i++) begin
      dispatch_entries[i] = '{dest_arch: 5'(seq), T: 6'(10 + seq), Told: 6'(40 + seq),
                              has_dest: 1'b1, is_branch: 1'b0};
      seq++;
    end
  endtask

  task automatic cpl(int lane, int idx, bit mp);
    complete_valid[lane]      = 1'b1;
    complete_idx[lane]        = IB'(idx);
    complete_mispredict[lane] = mp;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seq = 0;
  endtask

  initial begin
    int k;
    idle();
    reset = 1'b1;
    tick();
    started = 1'b1;
    tick();
    reset = 1'b0;

    // reset state
    @(negedge clock);
    chk("rst_spots", int'(spots), 3);
    chk("rst_full", int'(full), 0);
    chk("rst_rv", int'(retire_valid), 0);
    chk("rst_flush", int'(flush), 0);
    chk("rst_didx1", int'(dispatch_idx[1]), 1);
    chk("rst_didx2", int'(dispatch_idx[2]), 2);
    tick();

    // fill and overflow
    disp(3); tick();
    disp(3); @(negedge clock); chk("fill_didx0", int'(dispatch_idx[0]), 3); tick();
    disp(3); @(negedge clock); chk("fill_spots", int'(spots), 2);
    chk("fill_didx2", int'(dispatch_idx[2]), 0); tick();
    @(negedge clock); chk("full_full", int'(full), 1); chk("full_spots", int'(spots), 0);

    // out-of-order completion
    cpl(0, 2, 0); @(negedge clock); chk("ooo_rv_a", int'(retire_valid), 0); tick();
    cpl(0, 1, 0); @(negedge clock); chk("ooo_rv_b", int'(retire_valid), 0); tick();
    cpl(0, 0, 0); @(negedge clock); chk("ooo_rv_c", int'(retire_valid), 0); tick();
    @(negedge clock);
    chk("ooo_rv", int'(retire_valid), 7);
    chk("ooo_T0", int'(retire_entries[0].T), 10);
    chk("ooo_T2", int'(retire_entries[2].T), 12);
    chk("ooo_Told1", int'(retire_entries[1].Told), 41);
    tick();

    // wrap-around
    do_reset();
    disp(3); tick();
    disp(3); cpl(0, 0, 0); cpl(1, 1, 0); cpl(2, 2, 0); tick();
    cpl(0, 3, 0); cpl(1, 4, 0); cpl(2, 5, 0); tick();
    tick();
    disp(3); @(negedge clock);
    chk("wrap_didx0", int'(dispatch_idx[0]), 6);
    chk("wrap_didx2", int'(dispatch_idx[2]), 0); tick();
    cpl(0, 6, 0); cpl(1, 7, 0); cpl(2, 0, 0); tick();
    @(negedge clock);
    chk("wrap_rv", int'(retire_valid), 7);
    chk("wrap_T0", int'(retire_entries[0].T), 16);
    chk("wrap_T2", int'(retire_entries[2].T), 18); tick();
    @(negedge clock); chk("wrap_tail", int'(dispatch_idx[0]), 1); chk("wrap_spots", int'(spots), 3); tick();

    // mispredict flush
    do_reset();
    disp(3); tick();
    disp(2); cpl(0, 0, 0); cpl(1, 1, 1); cpl(2, 2, 0); tick();
    cpl(0, 3, 0); cpl(1, 4, 0); @(negedge clock);
    chk("mp_rv", int'(retire_valid), 3); chk("mp_flush", int'(flush), 1); tick();
    @(negedge clock);
    chk("mp_spots", int'(spots), 3); chk("mp_rv_after", int'(retire_valid), 0);
    chk("mp_head", int'(dispatch_idx[0]), 2); chk("mp_flush_after", int'(flush), 0);
    disp(3); tick();
    @(negedge clock); chk("mp_stale_cpl", int'(retire_valid), 0); tick();

    // reset mid-operation
    do_reset();
    disp(3); tick(); disp(3); tick(); disp(2); tick();
    cpl(0, 3, 0); cpl(1, 4, 0); tick();
    @(negedge clock); chk("mid_full", int'(full), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clock);
    chk("mid_spots", int'(spots), 3); chk("mid_full0", int'(full), 0);
    chk("mid_rv", int'(retire_valid), 0);
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      dispatch_cnt = CB'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
          k = $urandom_range(0, q.size() - 1);
          cpl(i, (mhead + k) % DEPTH, ($urandom_range(0, 9) == 0));
        end
      end
      tick();
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
